// File: rtl/load_ctrl_pkg.sv
// Shared types, default widths and a period helper for the load controller.
package load_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_TCW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Auto-reload period in cycles for a start/end window on a w-bit counter.
  function automatic int period_f(input int s, input int e, input int w = DEF_WIDTH);
    return ((e - s) & ((1 << w) - 1)) + 1;
  endfunction

endpackage

// File: rtl/load_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops once all bits are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/load_ctrl.sv
// Sequencer that loads an external counter and ticks when it reaches an end value.
module load_ctrl
  import load_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TCW   = DEF_TCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic             cfg_auto,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] din,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [TCW-1:0]   tick_cnt
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_end;
  logic             r_auto;
  logic             r_done;
  logic             w_done_next;
  logic             w_accept;
  logic             w_load;
  logic             w_tick;
  logic             w_cfg_ready;

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Latch the window only on an accepted handshake; ignored outside IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= '0;
      r_end   <= '0;
      r_auto  <= 1'b0;
    end else if (w_accept) begin
      r_start <= cfg_start;
      r_end   <= cfg_end;
      r_auto  <= cfg_auto;
    end
  end

  // Next-state and decoded outputs; abort overrides everything outside IDLE.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_tick       = 1'b0;
    w_cfg_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (count == r_end) begin
          w_tick = 1'b1;
          if (r_auto) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  sat_counter #(.W(TCW)) u_tick_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_inc (w_tick),
    .o_cnt (tick_cnt)
  );

  assign cfg_ready = w_cfg_ready;
  assign load      = w_load;
  assign tick      = w_tick;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign din       = r_start;

endmodule
